// File: rtl/spi_bus_arbiter.sv
// Two-master SPI bus arbiter with round-robin req/gnt, an enforced idle gap between
// owners and no preemption; the owner's pins are steered combinationally from the grant.
module spi_bus_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_HOLD   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    input  logic m0_clk,
    input  logic m0_cs_n,
    input  logic m0_mosi,
    output logic m0_miso,
    input  logic m1_clk,
    input  logic m1_cs_n,
    input  logic m1_mosi,
    output logic m1_miso,
    output logic spi_clk,
    output logic spi_mosi,
    input  logic spi_miso,
    output logic spi_cs0_n,
    output logic spi_cs1_n,
    output logic err
);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1'b1);
    localparam logic [GAP_W-1:0]  GAP_ZERO  = GAP_W'(1'b0);
    localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(1'b0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t              state_r;
    logic                gnt0_r;
    logic                gnt1_r;
    logic                last_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                err_r;

    logic                any_req_s;
    logic                win_s;
    state_t              arb_state_s;
    logic                arb_gnt0_s;
    logic                arb_gnt1_s;
    logic                arb_last_s;
    logic [HOLD_W-1:0]   hold_inc_s;

    // Round-robin choice among current requests; last_r names the previous owner
    always_comb begin
        any_req_s   = req0 | req1;
        win_s       = 1'b0;
        arb_state_s = ST_IDLE;
        arb_gnt0_s  = 1'b0;
        arb_gnt1_s  = 1'b0;
        arb_last_s  = last_r;
        if (req0 && req1) begin
            win_s = ~last_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (any_req_s) begin
            arb_state_s = win_s ? ST_GRANT1 : ST_GRANT0;
            arb_gnt0_s  = ~win_s;
            arb_gnt1_s  = win_s;
            arb_last_s  = win_s;
        end else begin
            arb_state_s = ST_IDLE;
            arb_gnt0_s  = 1'b0;
            arb_gnt1_s  = 1'b0;
            arb_last_s  = last_r;
        end
        hold_inc_s = hold_cnt_r + HOLD_ONE;
    end

    // Arbitration FSM with registered grants, gap/hold counters and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            last_r     <= 1'b1;
            gap_cnt_r  <= GAP_ZERO;
            hold_cnt_r <= HOLD_ZERO;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= arb_state_s;
                    gnt0_r     <= arb_gnt0_s;
                    gnt1_r     <= arb_gnt1_s;
                    last_r     <= arb_last_s;
                    hold_cnt_r <= HOLD_ZERO;
                end
                ST_GRANT0: begin
                    if (!req0) begin
                        if (!m0_cs_n) err_r <= 1'b1;
                        // With no gap the waiting master takes over on the release edge
                        if (GAP_CYCLES == 0) begin
                            state_r    <= arb_state_s;
                            gnt0_r     <= arb_gnt0_s;
                            gnt1_r     <= arb_gnt1_s;
                            last_r     <= arb_last_s;
                            hold_cnt_r <= HOLD_ZERO;
                        end else begin
                            state_r   <= ST_GAP;
                            gnt0_r    <= 1'b0;
                            gap_cnt_r <= GAP_LOAD;
                        end
                    end else if (MAX_HOLD != 0 && hold_cnt_r != HOLD_LIM) begin
                        hold_cnt_r <= hold_inc_s;
                        if (hold_inc_s == HOLD_LIM) err_r <= 1'b1;
                    end
                end
                ST_GRANT1: begin
                    if (!req1) begin
                        if (!m1_cs_n) err_r <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_r    <= arb_state_s;
                            gnt0_r     <= arb_gnt0_s;
                            gnt1_r     <= arb_gnt1_s;
                            last_r     <= arb_last_s;
                            hold_cnt_r <= HOLD_ZERO;
                        end else begin
                            state_r   <= ST_GAP;
                            gnt1_r    <= 1'b0;
                            gap_cnt_r <= GAP_LOAD;
                        end
                    end else if (MAX_HOLD != 0 && hold_cnt_r != HOLD_LIM) begin
                        hold_cnt_r <= hold_inc_s;
                        if (hold_inc_s == HOLD_LIM) err_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r <= GAP_ONE) begin
                        state_r    <= arb_state_s;
                        gnt0_r     <= arb_gnt0_s;
                        gnt1_r     <= arb_gnt1_s;
                        last_r     <= arb_last_s;
                        gap_cnt_r  <= GAP_ZERO;
                        hold_cnt_r <= HOLD_ZERO;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt0_r  <= 1'b0;
                    gnt1_r  <= 1'b0;
                end
            endcase
        end
    end

    // Steer the owner's pins; everything idles when nobody holds the bus
    always_comb begin
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        spi_cs0_n = 1'b1;
        spi_cs1_n = 1'b1;
        m0_miso   = 1'b0;
        m1_miso   = 1'b0;
        if (gnt0_r) begin
            spi_clk   = m0_clk;
            spi_mosi  = m0_mosi;
            spi_cs0_n = m0_cs_n;
            m0_miso   = spi_miso;
        end else if (gnt1_r) begin
            spi_clk   = m1_clk;
            spi_mosi  = m1_mosi;
            spi_cs1_n = m1_cs_n;
            m1_miso   = spi_miso;
        end else begin
            spi_clk   = 1'b0;
            spi_mosi  = 1'b0;
        end
    end

    assign gnt0 = gnt0_r;
    assign gnt1 = gnt1_r;
    assign err  = err_r;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: two instances (gap 2 / hold 8, and gap 0 / unlimited)
// share stimulus; a rule-level model predicts every cycle's outputs, a monitor compares.
module tb_spi_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic m0_clk = 1'b0, m0_cs_n = 1'b1, m0_mosi = 1'b0;
    logic m1_clk = 1'b0, m1_cs_n = 1'b1, m1_mosi = 1'b0;
    logic spi_miso = 1'b0;

    logic gnt0_a, gnt1_a, m0_miso_a, m1_miso_a, spi_clk_a, spi_mosi_a, spi_cs0_n_a, spi_cs1_n_a, err_a;
    logic gnt0_b, gnt1_b, m0_miso_b, m1_miso_b, spi_clk_b, spi_mosi_b, spi_cs0_n_b, spi_cs1_n_b, err_b;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.GAP_CYCLES(2), .MAX_HOLD(8)) u_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .gnt0(gnt0_a), .gnt1(gnt1_a),
        .m0_clk(m0_clk), .m0_cs_n(m0_cs_n), .m0_mosi(m0_mosi), .m0_miso(m0_miso_a),
        .m1_clk(m1_clk), .m1_cs_n(m1_cs_n), .m1_mosi(m1_mosi), .m1_miso(m1_miso_a),
        .spi_clk(spi_clk_a), .spi_mosi(spi_mosi_a), .spi_miso(spi_miso),
        .spi_cs0_n(spi_cs0_n_a), .spi_cs1_n(spi_cs1_n_a), .err(err_a)
    );

    spi_bus_arbiter #(.GAP_CYCLES(0), .MAX_HOLD(0)) u_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .gnt0(gnt0_b), .gnt1(gnt1_b),
        .m0_clk(m0_clk), .m0_cs_n(m0_cs_n), .m0_mosi(m0_mosi), .m0_miso(m0_miso_b),
        .m1_clk(m1_clk), .m1_cs_n(m1_cs_n), .m1_mosi(m1_mosi), .m1_miso(m1_miso_b),
        .spi_clk(spi_clk_b), .spi_mosi(spi_mosi_b), .spi_miso(spi_miso),
        .spi_cs0_n(spi_cs0_n_b), .spi_cs1_n(spi_cs1_n_b), .err(err_b)
    );

    typedef struct packed {
        bit busy;
        bit owner;
        int gap_left;
        bit last;
        int held;
        bit err;
    } mst_t;

    mst_t ma = '0;
    mst_t mb = '0;
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Rule-level model: advance one clock edge using the inputs present at that edge
    function automatic mst_t step(input mst_t s, input int gap, input int maxh);
        mst_t n;
        bit choose;
        bit own_req;
        bit own_cs;
        n = s;
        choose = 1'b0;
        if (reset) begin
            n = '0;
            n.last = 1'b1;
            return n;
        end
        own_req = s.owner ? req1 : req0;
        own_cs  = s.owner ? m1_cs_n : m0_cs_n;
        if (s.busy) begin
            if (own_req) begin
                n.held = s.held + 1;
                if (maxh != 0 && n.held >= maxh) n.err = 1'b1;
            end else begin
                if (!own_cs) n.err = 1'b1;
                n.busy = 1'b0;
                if (gap > 0) n.gap_left = gap;
                else choose = 1'b1;
            end
        end else if (s.gap_left > 0) begin
            n.gap_left = s.gap_left - 1;
            choose = (n.gap_left == 0);
        end else begin
            choose = 1'b1;
        end
        if (choose && (req0 || req1)) begin
            n.busy  = 1'b1;
            n.owner = (req0 && req1) ? ~s.last : req1;
            n.last  = n.owner;
            n.held  = 0;
        end
        return n;
    endfunction

    // Expected {gnt0,gnt1,err,spi_clk,spi_mosi,cs0_n,cs1_n,m0_miso,m1_miso}
    function automatic logic [8:0] expv(input mst_t s);
        logic [8:0] v;
        v = {1'b0, 1'b0, s.err, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        if (s.busy && !s.owner)
            v = {1'b1, 1'b0, s.err, m0_clk, m0_mosi, m0_cs_n, 1'b1, spi_miso, 1'b0};
        else if (s.busy && s.owner)
            v = {1'b0, 1'b1, s.err, m1_clk, m1_mosi, 1'b1, m1_cs_n, 1'b0, spi_miso};
        return v;
    endfunction

    task automatic tick(input bit rst, input bit r0, input bit r1, input bit c0, input bit c1);
        @(posedge clk);
        #1;
        ma = step(ma, 2, 8);
        mb = step(mb, 0, 0);
        reset    = rst;
        req0     = r0;
        req1     = r1;
        m0_cs_n  = c0;
        m1_cs_n  = c1;
        m0_clk   = 1'($urandom);
        m0_mosi  = 1'($urandom);
        m1_clk   = 1'($urandom);
        m1_mosi  = 1'($urandom);
        spi_miso = 1'($urandom);
        qa.push_back(expv(ma));
        qb.push_back(expv(mb));
    endtask

    task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got {gnt0,gnt1,err,clk,mosi,cs0_n,cs1_n,miso0,miso1}=%b expected %b",
                     nm, $time, got, exp);
        end
    endtask

    // Monitor: compare each instance's outputs against the queued prediction
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("inst_gap2_hold8", {gnt0_a, gnt1_a, err_a, spi_clk_a, spi_mosi_a,
                      spi_cs0_n_a, spi_cs1_n_a, m0_miso_a, m1_miso_a}, e);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("inst_gap0", {gnt0_b, gnt1_b, err_b, spi_clk_b, spi_mosi_b,
                      spi_cs0_n_b, spi_cs1_n_b, m0_miso_b, m1_miso_b}, e);
            end
        end
    end

    // Driver: directed scenarios first, then randomized traffic with occasional resets
    initial begin
        bit r0, r1, c0, c1, rst;
        tick(1, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        repeat (5) tick(0, 1, 0, 0, 1);
        repeat (3) tick(0, 1, 1, 0, 1);
        repeat (7) tick(0, 0, 1, 1, 0);
        repeat (5) tick(0, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        for (int k = 0; k < 8; k++) begin
            repeat (3) tick(0, 1, 1, 1, 1);
            tick(0, 0, 0, 1, 1);
        end
        repeat (4) tick(0, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        repeat (3) tick(0, 1, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        repeat (3) tick(0, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        repeat (20) tick(0, 0, 1, 1, 0);
        repeat (4) tick(0, 0, 0, 1, 1);
        repeat (3) tick(0, 0, 1, 1, 0);
        tick(1, 0, 1, 1, 0);
        repeat (3) tick(0, 0, 0, 1, 1);
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) r0 = ~r0;
            if ($urandom_range(0, 7) == 0) r1 = ~r1;
            c0 = r0 ? 1'($urandom) : (($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1);
            c1 = r1 ? 1'($urandom) : (($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1);
            tick(rst, r0, r1, c0, c1);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d/%0d entries left expected 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
